alu4_arith_unit: RTL and testbench

//  4-bit registered arithmetic/logic unit for the Day-6 datapath.
//  - Arithmetic: FullAdderVector (ripple add) and FullSubtractorVector (ripple subtract).
//  - Logic: AND4, plus inline OR/XOR.
//  - One op per cycle selected by sel; result and flags registered, latency 1.

---
 rtl/alu4_arith_unit_if.sv | 27 ++
 rtl/alu4_arith_unit.sv | 173 +++++++++++++++++
 tb/tb_alu4_arith_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu4_arith_unit_if.sv
// alu4_arith_unit_if
// Purpose : request/response bundle for the registered 4-bit ALU.
// Signals : in_valid/a/b/sel    - operation request, driven by the master
//           out/c/v/z/out_valid - registered result and flags, driven by the slave
interface alu4_arith_unit_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       sel;
  logic [WIDTH-1:0] out;
  logic             c;
  logic             v;
  logic             z;
  logic             out_valid;

  modport master (
    output in_valid, a, b, sel,
    input  out, c, v, z, out_valid
  );

  modport slave (
    input  in_valid, a, b, sel,
    output out, c, v, z, out_valid
  );
endinterface

// File: rtl/alu4_arith_unit.sv
// alu4_arith_unit
// Purpose : one-cycle-latency arithmetic/logic unit. Ripple add / ripple
//           subtract plus AND/OR/XOR; result and carry/overflow/zero flags
//           are registered together when in_valid is sampled high.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - slave side of alu4_arith_unit_if (request in, result out)
module alu4_arith_unit #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu4_arith_unit_if.slave   bus
);

  // Ripple-carry adder; returns {carry_out, sum}.
  function automatic logic [WIDTH:0] full_adder_vector(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             cin
  );
    logic [WIDTH-1:0] sum_v;
    logic             carry_v;
    carry_v = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum_v[i] = x[i] ^ y[i] ^ carry_v;
      carry_v  = (x[i] & y[i]) | (carry_v & (x[i] ^ y[i]));
    end
    return {carry_v, sum_v};
  endfunction

  // Ripple-borrow subtractor computing x - y; returns {borrow_out, diff}.
  function automatic logic [WIDTH:0] full_subtractor_vector(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             bin
  );
    logic [WIDTH-1:0] diff_v;
    logic             borrow_v;
    borrow_v = bin;
    for (int i = 0; i < WIDTH; i++) begin
      diff_v[i] = x[i] ^ y[i] ^ borrow_v;
      borrow_v  = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & borrow_v);
    end
    return {borrow_v, diff_v};
  endfunction

  // Signed overflow of x + y given the truncated sum.
  function automatic logic add_ovf(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic [WIDTH-1:0] s
  );
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // Signed overflow of x - y given the truncated difference.
  function automatic logic sub_ovf(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic [WIDTH-1:0] d
  );
    return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
  endfunction

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub_ab;
  logic [WIDTH:0]   w_sub_ba;
  logic [WIDTH-1:0] w_out;
  logic             w_c;
  logic             w_v;

  logic [WIDTH-1:0] r_out;
  logic             r_c;
  logic             r_v;
  logic             r_z;
  logic             r_out_valid;

  assign w_add    = full_adder_vector(bus.a, bus.b, 1'b0);
  assign w_sub_ab = full_subtractor_vector(bus.a, bus.b, 1'b0);
  assign w_sub_ba = full_subtractor_vector(bus.b, bus.a, 1'b0);

  // Operation decode: next result and flags from the current operands.
  always_comb begin
    w_out = {WIDTH{1'b0}};
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (bus.sel)
      3'b000: begin
        w_out = {WIDTH{1'b0}};
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
      3'b001: begin
        w_out = w_sub_ba[WIDTH-1:0];
        w_c   = w_sub_ba[WIDTH];
        w_v   = sub_ovf(bus.b, bus.a, w_sub_ba[WIDTH-1:0]);
      end
      3'b010: begin
        w_out = w_sub_ab[WIDTH-1:0];
        w_c   = w_sub_ab[WIDTH];
        w_v   = sub_ovf(bus.a, bus.b, w_sub_ab[WIDTH-1:0]);
      end
      3'b011: begin
        w_out = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = add_ovf(bus.a, bus.b, w_add[WIDTH-1:0]);
      end
      3'b100: begin
        w_out = bus.a ^ bus.b;
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
      3'b101: begin
        w_out = bus.a | bus.b;
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
      3'b110: begin
        w_out = bus.a & bus.b;
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
      3'b111: begin
        // Deliberate "all ones" pattern with both flags raised.
        w_out = {WIDTH{1'b1}};
        w_c   = 1'b1;
        w_v   = 1'b1;
      end
      default: begin
        w_out = {WIDTH{1'b0}};
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
    endcase
  end

  // Result/flag registers: load on in_valid, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= {WIDTH{1'b0}};
      r_c   <= 1'b0;
      r_v   <= 1'b0;
      r_z   <= 1'b1;
    end else if (bus.in_valid) begin
      r_out <= w_out;
      r_c   <= w_c;
      r_v   <= w_v;
      r_z   <= ~|w_out;
    end else begin
      r_out <= r_out;
      r_c   <= r_c;
      r_v   <= r_v;
      r_z   <= r_z;
    end
  end

  // Output-valid pipeline: follows in_valid by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
    end
  end

  assign bus.out       = r_out;
  assign bus.c         = r_c;
  assign bus.v         = r_v;
  assign bus.z         = r_z;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_alu4_arith_unit.sv
// tb_alu4_arith_unit
// Purpose : directed self-checking bench for alu4_arith_unit. Each check
//           compares the packed vector {out, c, v, z, out_valid} against a
//           hand-computed constant.
module tb_alu4_arith_unit;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  alu4_arith_unit_if #(.WIDTH(4)) bus ();

  alu4_arith_unit #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_v(
    input logic [3:0] o,
    input logic       c,
    input logic       v,
    input logic       z,
    input logic       ov
  );
    return {o, c, v, z, ov};
  endfunction

  task automatic check(input string tag, input logic [7:0] expected);
    logic [7:0] observed;
    observed = {bus.out, bus.c, bus.v, bus.z, bus.out_valid};
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed{out,c,v,z,ov}=%b required=%b", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic iv, input logic [3:0] va, input logic [3:0] vb,
                       input logic [2:0] vs);
    bus.in_valid = iv;
    bus.a        = va;
    bus.b        = vb;
    bus.sel      = vs;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] sweep_exp [8];

  initial begin
    vectors     = 0;
    miscompares = 0;
    sweep_exp[0] = exp_v(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
    sweep_exp[1] = exp_v(4'b1101, 1'b0, 1'b0, 1'b0, 1'b1);
    sweep_exp[2] = exp_v(4'b0011, 1'b1, 1'b0, 1'b0, 1'b1);
    sweep_exp[3] = exp_v(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
    sweep_exp[4] = exp_v(4'b1101, 1'b0, 1'b0, 1'b0, 1'b1);
    sweep_exp[5] = exp_v(4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
    sweep_exp[6] = exp_v(4'b0010, 1'b0, 1'b0, 1'b0, 1'b1);
    sweep_exp[7] = exp_v(4'b1111, 1'b1, 1'b1, 1'b0, 1'b1);

    // Reset state.
    rst_n = 1'b0;
    drive(1'b1, 4'b0111, 4'b0001, 3'b011);
    @(negedge clk);
    @(negedge clk);
    check("reset", exp_v(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0));

    // Release with in_valid=0: values held.
    drive(1'b0, 4'b0111, 4'b0001, 3'b011);
    rst_n = 1'b1;
    step();
    check("release_hold0", exp_v(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0));
    step();
    check("release_hold1", exp_v(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0));

    // Sweep a=0010, b=1111 across every sel.
    for (int s = 0; s < 8; s++) begin
      drive(1'b1, 4'b0010, 4'b1111, s[2:0]);
      step();
      check($sformatf("sweep_sel%0d", s), sweep_exp[s]);
    end

    // Signed overflow cases.
    drive(1'b1, 4'b0111, 4'b0001, 3'b011);
    step();
    check("ovf_add", exp_v(4'b1000, 1'b0, 1'b1, 1'b0, 1'b1));
    drive(1'b1, 4'b1000, 4'b0001, 3'b010);
    step();
    check("ovf_sub", exp_v(4'b0111, 1'b0, 1'b1, 1'b0, 1'b1));

    // Hold: inputs change with in_valid=0.
    drive(1'b0, 4'b1111, 4'b1111, 3'b011);
    step();
    check("hold0", exp_v(4'b0111, 1'b0, 1'b1, 1'b0, 1'b0));
    drive(1'b0, 4'b0000, 4'b0101, 3'b111);
    step();
    check("hold1", exp_v(4'b0111, 1'b0, 1'b1, 1'b0, 1'b0));

    // Zero / wrap.
    drive(1'b1, 4'b1111, 4'b0001, 3'b011);
    step();
    check("wrap_add", exp_v(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1));
    drive(1'b1, 4'b0101, 4'b0101, 3'b010);
    step();
    check("zero_sub", exp_v(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1));

    // Async reset mid-burst, between clock edges.
    drive(1'b1, 4'b0111, 4'b0001, 3'b011);
    step();
    check("pre_reset", exp_v(4'b1000, 1'b0, 1'b1, 1'b0, 1'b1));
    drive(1'b0, 4'b0111, 4'b0001, 3'b011);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_clear", exp_v(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0));
    #1;
    rst_n = 1'b1;
    drive(1'b1, 4'b0011, 4'b0101, 3'b001);
    @(negedge clk);
    check("post_reset", exp_v(4'b0010, 1'b0, 1'b0, 1'b0, 1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
